// File: rtl/control_pipeline_pkg.sv
// Shared encodings for the ID/EX/MEM/WB control pipeline: forwarding selects,
// writeback-control bit positions and the hardwired zero register.
package control_pipeline_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int ALUOP_W_DEF    = 4;

  // Bit positions inside the 2-bit writeback control word.
  localparam int WBI_SRC      = 0;
  localparam int WBI_REGWRITE = 1;

  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10
  } fwd_sel_e;

  // The younger producer (MEM) always wins over the older one (WB).
  function automatic fwd_sel_e fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/control_pipeline_if.sv
// Decoder-side control word into the pipeline and the per-stage control
// outputs towards the ALU, data memory and writeback muxes.
interface control_pipeline_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 4
);

  logic                  id_valid;
  logic [ALUOP_W-1:0]    id_aluOp;
  logic                  id_isJump;
  logic                  id_isNotConditional;
  logic                  id_isEq;
  logic                  id_memWrite;
  logic                  id_memRead;
  logic                  id_aluSrc;
  logic                  id_regDst;
  logic [1:0]            id_wbi;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;

  logic [ALUOP_W-1:0]    ex_aluOp;
  logic                  ex_aluSrc;
  logic                  ex_isJump;
  logic                  ex_isNotConditional;
  logic                  ex_isEq;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  mem_memRead;
  logic                  mem_memWrite;
  logic [1:0]            wb_wbi;
  logic [REG_ADDR_W-1:0] wb_dest;

  modport master (
    output id_valid, id_aluOp, id_isJump, id_isNotConditional, id_isEq,
           id_memWrite, id_memRead, id_aluSrc, id_regDst, id_wbi,
           id_rs, id_rt, id_rd,
    input  ex_aluOp, ex_aluSrc, ex_isJump, ex_isNotConditional, ex_isEq,
           ex_rs, ex_rt, fwd_a, fwd_b, mem_memRead, mem_memWrite,
           wb_wbi, wb_dest
  );

  modport slave (
    input  id_valid, id_aluOp, id_isJump, id_isNotConditional, id_isEq,
           id_memWrite, id_memRead, id_aluSrc, id_regDst, id_wbi,
           id_rs, id_rt, id_rd,
    output ex_aluOp, ex_aluSrc, ex_isJump, ex_isNotConditional, ex_isEq,
           ex_rs, ex_rt, fwd_a, fwd_b, mem_memRead, mem_memWrite,
           wb_wbi, wb_dest
  );

endinterface

// File: rtl/control_pipeline_hazard_fwd_unit.sv
// Combinational hazard/forwarding unit: load-use stall detection against the
// instruction in ID, and EX operand forwarding selects from MEM and WB.
module control_pipeline_hazard_fwd_unit
  import control_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid_i,
  input  logic                  id_alu_src_i,
  input  logic                  id_mem_write_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_dest_i,
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic                  mem_valid_i,
  input  logic [1:0]            mem_wbi_i,
  input  logic [REG_ADDR_W-1:0] mem_dest_i,
  input  logic                  wb_valid_i,
  input  logic [1:0]            wb_wbi_i,
  input  logic [REG_ADDR_W-1:0] wb_dest_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output fwd_sel_e              fwd_a_o,
  output fwd_sel_e              fwd_b_o
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(REG_ZERO);

  logic uses_rt;
  logic load_hit;
  logic mem_can_fwd;
  logic wb_can_fwd;

  // Stores read rt as data even though aluSrc selects the immediate.
  assign uses_rt  = ~id_alu_src_i | id_mem_write_i;
  assign load_hit = ex_valid_i & ex_mem_read_i & (ex_dest_i != ZERO_REG) &
                    ((ex_dest_i == id_rs_i) | (uses_rt & (ex_dest_i == id_rt_i)));

  // A flush kills the ID instruction, so there is nothing left to hold.
  assign stall_o = id_valid_i & load_hit & ~flush_i;

  // Loads sitting in MEM have no result yet (wbi src = memory), so only ALU results forward from MEM.
  assign mem_can_fwd = mem_valid_i & mem_wbi_i[WBI_REGWRITE] & mem_wbi_i[WBI_SRC] &
                       (mem_dest_i != ZERO_REG);
  assign wb_can_fwd  = wb_valid_i & wb_wbi_i[WBI_REGWRITE] & (wb_dest_i != ZERO_REG);

  assign fwd_a_o = fwd_select(mem_can_fwd & (mem_dest_i == ex_rs_i),
                              wb_can_fwd  & (wb_dest_i  == ex_rs_i));
  assign fwd_b_o = fwd_select(mem_can_fwd & (mem_dest_i == ex_rt_i),
                              wb_can_fwd  & (wb_dest_i  == ex_rt_i));

endmodule

// File: rtl/control_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control-word registers with stall/flush handling on
// the ID->EX boundary and valid-gating of every stage's outputs.
module control_pipeline
  import control_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int ALUOP_W    = ALUOP_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  output logic              stall_o,
  control_pipeline_if.slave bus
);

  logic                  ex_valid_q, ex_valid_d;
  logic [ALUOP_W-1:0]    ex_alu_op_q;
  logic                  ex_alu_src_q, ex_is_jump_q, ex_is_not_cond_q, ex_is_eq_q;
  logic                  ex_mem_read_q, ex_mem_write_q;
  logic [1:0]            ex_wbi_q;
  logic [REG_ADDR_W-1:0] ex_dest_q, ex_dest_d, ex_rs_q, ex_rt_q;

  logic                  mem_valid_q, mem_mem_read_q, mem_mem_write_q;
  logic [1:0]            mem_wbi_q;
  logic [REG_ADDR_W-1:0] mem_dest_q;

  logic                  wb_valid_q;
  logic [1:0]            wb_wbi_q;
  logic [REG_ADDR_W-1:0] wb_dest_q;

  logic [REG_ADDR_W-1:0] ex_rs_g, ex_rt_g;
  fwd_sel_e              fwd_a, fwd_b;

  always_comb begin
    ex_valid_d = bus.id_valid & ~flush_i & ~stall_o;
    ex_dest_d  = bus.id_regDst ? bus.id_rd : bus.id_rt;
  end

  // ID -> EX. Fields load every edge; a bubble is expressed through ex_valid_q alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q       <= 1'b0;
      ex_alu_op_q      <= '0;
      ex_alu_src_q     <= 1'b0;
      ex_is_jump_q     <= 1'b0;
      ex_is_not_cond_q <= 1'b0;
      ex_is_eq_q       <= 1'b0;
      ex_mem_read_q    <= 1'b0;
      ex_mem_write_q   <= 1'b0;
      ex_wbi_q         <= '0;
      ex_dest_q        <= '0;
      ex_rs_q          <= '0;
      ex_rt_q          <= '0;
    end else begin
      ex_valid_q       <= ex_valid_d;
      ex_alu_op_q      <= bus.id_aluOp;
      ex_alu_src_q     <= bus.id_aluSrc;
      ex_is_jump_q     <= bus.id_isJump;
      ex_is_not_cond_q <= bus.id_isNotConditional;
      ex_is_eq_q       <= bus.id_isEq;
      ex_mem_read_q    <= bus.id_memRead;
      ex_mem_write_q   <= bus.id_memWrite;
      ex_wbi_q         <= bus.id_wbi;
      ex_dest_q        <= ex_dest_d;
      ex_rs_q          <= bus.id_rs;
      ex_rt_q          <= bus.id_rt;
    end
  end

  // EX -> MEM -> WB, no back-pressure downstream of EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid_q     <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      mem_mem_write_q <= 1'b0;
      mem_wbi_q       <= '0;
      mem_dest_q      <= '0;
      wb_valid_q      <= 1'b0;
      wb_wbi_q        <= '0;
      wb_dest_q       <= '0;
    end else begin
      mem_valid_q     <= ex_valid_q;
      mem_mem_read_q  <= ex_mem_read_q;
      mem_mem_write_q <= ex_mem_write_q;
      mem_wbi_q       <= ex_wbi_q;
      mem_dest_q      <= ex_dest_q;
      wb_valid_q      <= mem_valid_q;
      wb_wbi_q        <= mem_wbi_q;
      wb_dest_q       <= mem_dest_q;
    end
  end

  assign ex_rs_g = ex_valid_q ? ex_rs_q : '0;
  assign ex_rt_g = ex_valid_q ? ex_rt_q : '0;

  control_pipeline_hazard_fwd_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_fwd (
    .id_valid_i     (bus.id_valid),
    .id_alu_src_i   (bus.id_aluSrc),
    .id_mem_write_i (bus.id_memWrite),
    .id_rs_i        (bus.id_rs),
    .id_rt_i        (bus.id_rt),
    .ex_valid_i     (ex_valid_q),
    .ex_mem_read_i  (ex_mem_read_q),
    .ex_dest_i      (ex_dest_q),
    .ex_rs_i        (ex_rs_g),
    .ex_rt_i        (ex_rt_g),
    .mem_valid_i    (mem_valid_q),
    .mem_wbi_i      (mem_wbi_q),
    .mem_dest_i     (mem_dest_q),
    .wb_valid_i     (wb_valid_q),
    .wb_wbi_i       (wb_wbi_q),
    .wb_dest_i      (wb_dest_q),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b)
  );

  // Bubbles present all-zero controls so they can never write anything.
  always_comb begin
    bus.ex_aluOp            = '0;
    bus.ex_aluSrc           = 1'b0;
    bus.ex_isJump           = 1'b0;
    bus.ex_isNotConditional = 1'b0;
    bus.ex_isEq             = 1'b0;
    bus.mem_memRead         = 1'b0;
    bus.mem_memWrite        = 1'b0;
    bus.wb_wbi              = '0;
    bus.wb_dest             = '0;
    if (ex_valid_q) begin
      bus.ex_aluOp            = ex_alu_op_q;
      bus.ex_aluSrc           = ex_alu_src_q;
      bus.ex_isJump           = ex_is_jump_q;
      bus.ex_isNotConditional = ex_is_not_cond_q;
      bus.ex_isEq             = ex_is_eq_q;
    end
    if (mem_valid_q) begin
      bus.mem_memRead  = mem_mem_read_q;
      bus.mem_memWrite = mem_mem_write_q;
    end
    if (wb_valid_q) begin
      bus.wb_wbi  = wb_wbi_q;
      bus.wb_dest = wb_dest_q;
    end
  end

  assign bus.ex_rs = ex_rs_g;
  assign bus.ex_rt = ex_rt_g;
  assign bus.fwd_a = fwd_a;
  assign bus.fwd_b = fwd_b;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline with a writeback scoreboard.
module tb_control_pipeline;
  import control_pipeline_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush_i = 1'b0;
  logic stall_o;

  control_pipeline_if #(.REG_ADDR_W(5), .ALUOP_W(4)) ifc ();

  control_pipeline #(.REG_ADDR_W(5), .ALUOP_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [3:0] op;
    logic       j, nc, eq, mw, mr, as, rds;
    logic [1:0] wbi;
    logic [4:0] rs, rt, rd;
  } instr_t;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  instr_t cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t bubble();
    instr_t i = '0;
    return i;
  endfunction

  function automatic instr_t mk_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    instr_t i = '0;
    i.v = 1'b1; i.op = 4'h2; i.rds = 1'b1; i.wbi = 2'b11;
    i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t mk_lw(input logic [4:0] rt, input logic [4:0] rs);
    instr_t i = '0;
    i.v = 1'b1; i.mr = 1'b1; i.as = 1'b1; i.wbi = 2'b10;
    i.rs = rs; i.rt = rt; i.rd = 5'd31;
    return i;
  endfunction

  function automatic instr_t mk_sw(input logic [4:0] rt, input logic [4:0] rs);
    instr_t i = '0;
    i.v = 1'b1; i.mw = 1'b1; i.as = 1'b1;
    i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic instr_t mk_addi(input logic [4:0] rt, input logic [4:0] rs);
    instr_t i = '0;
    i.v = 1'b1; i.op = 4'h1; i.as = 1'b1; i.wbi = 2'b11;
    i.rs = rs; i.rt = rt; i.rd = 5'd30;
    return i;
  endfunction

  function automatic instr_t mk_j();
    instr_t i = '0;
    i.v = 1'b1; i.j = 1'b1; i.nc = 1'b1; i.op = 4'h7;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    cur = i;
    ifc.id_valid            = i.v;
    ifc.id_aluOp            = i.op;
    ifc.id_isJump           = i.j;
    ifc.id_isNotConditional = i.nc;
    ifc.id_isEq             = i.eq;
    ifc.id_memWrite         = i.mw;
    ifc.id_memRead          = i.mr;
    ifc.id_aluSrc           = i.as;
    ifc.id_regDst           = i.rds;
    ifc.id_wbi              = i.wbi;
    ifc.id_rs               = i.rs;
    ifc.id_rt               = i.rt;
    ifc.id_rd               = i.rd;
    #1;
  endtask

  // consumed: the bench's own expectation that this edge moves the ID word into EX.
  task automatic tick(input bit consumed);
    if (consumed && cur.v && cur.wbi != 2'b00)
      exp_q.push_back({cur.wbi, (cur.rds ? cur.rd : cur.rt)});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(bubble());
    repeat (4) tick(1'b0);
  endtask

  // Writeback scoreboard: every nonzero wb_wbi must match the oldest expected writer.
  always @(negedge clk) begin
    if (reset_n && ifc.wb_wbi != 2'b00) begin
      chk("wb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("wb_word", {25'd0, ifc.wb_wbi, ifc.wb_dest}, {25'd0, exp_q.pop_front()});
    end
  end

  initial begin
    drive(bubble());
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_ex_aluOp", ifc.ex_aluOp, 0);
    chk("rst_ex_rs", ifc.ex_rs, 0);
    chk("rst_fwd_a", ifc.fwd_a, 0);
    chk("rst_fwd_b", ifc.fwd_b, 0);
    chk("rst_mem_memRead", ifc.mem_memRead, 0);
    chk("rst_wb_wbi", ifc.wb_wbi, 0);
    reset_n = 1'b1;
    tick(1'b0);

    // Reset with three instructions in flight.
    drive(mk_r(5'd1, 5'd2, 5'd3));  tick(1'b1);
    drive(mk_r(5'd2, 5'd4, 5'd5));  tick(1'b1);
    drive(mk_lw(5'd3, 5'd6));       tick(1'b1);
    chk("pre_rst_ex_aluSrc", ifc.ex_aluSrc, 1);
    chk("pre_rst_wb_wbi", ifc.wb_wbi, 2'b11);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_ex_aluSrc", ifc.ex_aluSrc, 0);
    chk("mid_rst_ex_rs", ifc.ex_rs, 0);
    chk("mid_rst_wb_wbi", ifc.wb_wbi, 0);
    chk("mid_rst_wb_dest", ifc.wb_dest, 0);
    drive(bubble());
    reset_n = 1'b1;
    repeat (4) tick(1'b0);
    chk("post_rst_wb_wbi", ifc.wb_wbi, 0);

    // lw r8 ; add r9,r8,r2
    drive(mk_lw(5'd8, 5'd1));       tick(1'b1);
    chk("lw_ex_aluSrc", ifc.ex_aluSrc, 1);
    drive(mk_r(5'd9, 5'd8, 5'd2));
    chk("lu_stall", stall_o, 1);
    tick(1'b0);
    chk("lu_bubble_ex_rs", ifc.ex_rs, 0);
    chk("lu_bubble_ex_aluOp", ifc.ex_aluOp, 0);
    chk("lu_mem_memRead", ifc.mem_memRead, 1);
    chk("lu_stall_released", stall_o, 0);
    tick(1'b1);
    chk("lu_ex_rs", ifc.ex_rs, 8);
    chk("lu_ex_aluOp", ifc.ex_aluOp, 2);
    chk("lu_fwd_a", ifc.fwd_a, 2'b10);
    chk("lu_fwd_b", ifc.fwd_b, 2'b00);
    drain();

    // add r3,r1,r2 ; sub r4,r3,r3 back to back
    drive(mk_r(5'd3, 5'd1, 5'd2));  tick(1'b1);
    drive(mk_r(5'd4, 5'd3, 5'd3));
    chk("alu_nostall", stall_o, 0);
    tick(1'b1);
    chk("mem_fwd_a", ifc.fwd_a, 2'b01);
    chk("mem_fwd_b", ifc.fwd_b, 2'b01);
    drain();

    // Same pair with one bubble between
    drive(mk_r(5'd3, 5'd1, 5'd2));  tick(1'b1);
    drive(bubble());                tick(1'b0);
    drive(mk_r(5'd4, 5'd3, 5'd3));  tick(1'b1);
    chk("wb_fwd_a", ifc.fwd_a, 2'b10);
    chk("wb_fwd_b", ifc.fwd_b, 2'b10);
    drain();

    // Two writers of r5 in MEM and WB
    drive(mk_r(5'd5, 5'd1, 5'd2));  tick(1'b1);
    drive(mk_r(5'd5, 5'd6, 5'd7));  tick(1'b1);
    drive(mk_r(5'd10, 5'd5, 5'd5)); tick(1'b1);
    chk("prio_fwd_a", ifc.fwd_a, 2'b01);
    chk("prio_fwd_b", ifc.fwd_b, 2'b01);
    drain();

    // Writers targeting r0 never forward
    drive(mk_r(5'd0, 5'd1, 5'd2));  tick(1'b1);
    drive(mk_r(5'd0, 5'd3, 5'd4));  tick(1'b1);
    drive(mk_r(5'd11, 5'd0, 5'd0)); tick(1'b1);
    chk("r0_fwd_a", ifc.fwd_a, 2'b00);
    chk("r0_fwd_b", ifc.fwd_b, 2'b00);
    drain();

    // Jump reaches EX, flush collides with a load-use on sw r8
    drive(mk_j());                  tick(1'b1);
    chk("jmp_ex_isJump", ifc.ex_isJump, 1);
    chk("jmp_ex_isNotCond", ifc.ex_isNotConditional, 1);
    drive(mk_lw(5'd8, 5'd1));       tick(1'b1);
    drive(mk_sw(5'd8, 5'd2));
    chk("flush_pre_stall", stall_o, 1);
    flush_i = 1'b1;
    #1;
    chk("flush_stall_masked", stall_o, 0);
    tick(1'b0);
    flush_i = 1'b0;
    chk("flush_ex_isJump", ifc.ex_isJump, 0);
    chk("flush_ex_aluSrc", ifc.ex_aluSrc, 0);
    chk("flush_ex_rt", ifc.ex_rt, 0);
    drive(bubble());                tick(1'b0);
    chk("flush_mem_memWrite", ifc.mem_memWrite, 0);
    chk("flush_mem_memRead", ifc.mem_memRead, 0);
    drain();

    // Store after load of its data register; addi with rt=load dest
    drive(mk_lw(5'd7, 5'd1));       tick(1'b1);
    drive(mk_sw(5'd7, 5'd2));
    chk("sw_uses_rt_stall", stall_o, 1);
    drive(mk_addi(5'd7, 5'd1));
    chk("addi_rt_nostall", stall_o, 0);
    drive(bubble());                tick(1'b0);
    drain();
    drive(mk_lw(5'd6, 5'd1));       tick(1'b1);
    drive(mk_addi(5'd7, 5'd1));
    chk("addi_other_nostall", stall_o, 0);
    drive(mk_addi(5'd7, 5'd6));
    chk("addi_rs_stall", stall_o, 1);
    drive(bubble());                tick(1'b0);
    drain();

    // Load into r0 never stalls
    drive(mk_lw(5'd0, 5'd1));       tick(1'b1);
    drive(mk_r(5'd9, 5'd0, 5'd2));
    chk("lw_r0_nostall", stall_o, 0);
    drain();

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
